hilo_sequencer: RTL and testbench
=================================

# hilo_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and runs shift-add multiply or restoring divide over multiple cycles. While it runs, it drives a stall request into hazard detection so that dependent HI/LO traffic waits. It replaces the single-cycle multiply path plus separate HI/LO register block in the EX/MEM region.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width; iteration count equals WIDTH.

Ports:
- Clk  in  1  system clock (the divided pipeline clock); all state changes on rising edge.
- Reset  in  1  synchronous, active-low; sampled on the Clk rising edge.
- Start  in  1  request valid from EX stage, one cycle per instruction.
- Op  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved and ignored.
- OpA  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO source.
- OpB  in  WIDTH  rt value: multiplier or divisor.
- HiLoRead  in  1  MFHI/MFLO present in EX this cycle.
- Stall  out  1  combinational: Busy & (Start | HiLoRead).
- Busy  out  1  registered; high while a multiply or divide is in flight.
- Done  out  1  registered one-cycle pulse when HI/LO are updated by a multiply or divide.
- DivZero  out  1  registered one-cycle pulse, coincident with Done, on divide by zero.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

## Operation
States: IDLE, MUL, DIV, SIGN.

IDLE with Start=1:
- MTHI: HI<=OpA this edge; stay IDLE; no Done.
- MTLO: LO<=OpA this edge; stay IDLE; no Done.
- MULT/MULTU:
  - Latch the operand magnitudes (two's-complement abs for MULT, raw for MULTU).
  - Latch the negate flag = signA^signB (MULT only).
  - Counter<=WIDTH-1; go to MUL; Busy<=1.
- DIV/DIVU with OpB!=0:
  - Latch the magnitudes.
  - Latch qneg = signA^signB and rneg = signA (DIV only).
  - Counter<=WIDTH-1; go to DIV; Busy<=1.
- DIV/DIVU with OpB==0: HI/LO unchanged; Done<=1 and DivZero<=1 for one cycle; stay IDLE.
- Reserved Op: ignored.

MUL:
- One shift-add step per cycle on a 2*WIDTH product register.
- When Counter==0, go to SIGN; otherwise Counter decrements.

DIV:
- One restoring step per cycle: shift the remainder/quotient left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- When Counter==0, go to SIGN.

SIGN (one cycle):
- Multiply: apply the negate flag to the 2*WIDTH product; {HI,LO}<=product.
- Divide: LO<=quotient (negated if qneg); HI<=remainder (negated if rneg).
- Done<=1; Busy<=0; go to IDLE.

Other rules:
- Start while Busy is not accepted. Stall holds the requesting instruction in EX until Busy falls, and it is accepted on the first IDLE cycle.
- HiLoRead while Busy raises Stall. HI/LO outputs always reflect the committed registers and never a partial result.
- All arithmetic is modulo 2^WIDTH per result half.
- MULT 0x80000000*0x80000000 gives HI=0x40000000, LO=0.
- DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).

## Timing
- Reset (Reset=0 at an edge): state IDLE, Counter=0, HI=0, LO=0, Busy=0, Done=0, DivZero=0. This applies mid-operation too: an in-flight operation is abandoned and HI/LO are cleared.
- MTHI/MTLO latency: value visible on HI/LO one cycle after the Start edge.
- Multiply and divide latency:
  - Start sampled at edge 0.
  - Busy=1 from edge 0 through edge WIDTH.
  - SIGN is occupied after edge WIDTH, and HI/LO update plus the Done pulse occur at edge WIDTH+1.
  - For WIDTH=32, results are valid 33 edges after the Start edge.
- Back-to-back: a Start presented during the Done cycle is accepted at that cycle's edge, with Stall=0.
- Done and DivZero are never asserted for more than one cycle.

## Configuration
- HILO_DIV_EN defined: DIV/DIVU supported as described, including the DIV state and the divide datapath.
- HILO_DIV_EN undefined: the DIV state and divide datapath are removed. Op 010 and 011 are treated as reserved (ignored, no Done, no DivZero, HI/LO unchanged). DivZero is tied to 0.

## Test plan
- MULT OpA=0xFFFFFFFD (-3), OpB=7 -> Busy 33 cycles; at edge 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done pulse.
- DIVU OpA=100, OpB=7 -> at edge 33, LO=14, HI=2, Done=1, DivZero=0. DIV OpA=-7, OpB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI 0x1234 then DIV OpA=5, OpB=0 -> DivZero and Done pulse one cycle after Start; HI stays 0x1234 and LO stays unchanged; Busy never rises.
- During MULTU 0xFFFFFFFF*2, assert HiLoRead at cycle 5 and Start(MTLO) at cycle 10 -> Stall=1 both times. The MTLO is held until accepted in the Done cycle; final HI=1, then LO=the MTLO value.
- Reset=0 at cycle 12 of a DIV -> next cycle HI=LO=0, Busy=0, no Done. A new MULT 6*7 afterwards gives LO=42, HI=0.
- Build without HILO_DIV_EN, Start DIV 10/3 -> no Busy, no Done, HI/LO unchanged.

Source files
------------

// File: rtl/hilo_sequencer_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide sequencer.
interface hilo_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             HiLoRead;
    logic             Stall;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, OpA, OpB, HiLoRead,
        input  Stall, Busy, Done, DivZero, HI, LO
    );

    modport slave (
        input  Start, Op, OpA, OpB, HiLoRead,
        output Stall, Busy, Done, DivZero, HI, LO
    );
endinterface

// File: rtl/hilo_sequencer.sv
// Iterative shift-add multiply / restoring divide sequencer owning the HI/LO pair.
// Divide support is built only when HILO_DIV_EN is defined.
module hilo_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           Clk,
    input  logic           Reset,
    hilo_sequencer_if.slave bus
);
    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef HILO_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} stateT;
`else
    typedef enum logic [1:0] {IDLE, MUL, SIGN} stateT;
`endif

    stateT              state, stateNext;
    logic [CNT_W-1:0]   counter, counterNext;
    logic [PROD_W-1:0]  prod, prodNext;
    logic [WIDTH-1:0]   operand, operandNext;
    logic               negProd, negProdNext;
    logic [WIDTH-1:0]   hiReg, hiNext;
    logic [WIDTH-1:0]   loReg, loNext;
    logic               busyReg, busyNext;
    logic               doneReg, doneNext;
`ifdef HILO_DIV_EN
    logic               isDiv, isDivNext;
    logic               qNeg, qNegNext;
    logic               rNeg, rNegNext;
    logic               divZeroReg, divZeroNext;
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic [WIDTH-1:0]   quoFinal;
    logic [WIDTH-1:0]   remFinal;
`endif

    logic               signA, signB, isSigned;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum;
    logic [PROD_W-1:0]  prodFinal;

    // Operand magnitudes; signed ops (MULT, DIV) have an even Op code.
    assign signA     = bus.OpA[WIDTH-1];
    assign signB     = bus.OpB[WIDTH-1];
    assign isSigned  = ~bus.Op[0];
    assign absA      = (isSigned && signA) ? -bus.OpA : bus.OpA;
    assign absB      = (isSigned && signB) ? -bus.OpB : bus.OpB;
    assign prodFinal = negProd ? -prod : prod;
`ifdef HILO_DIV_EN
    assign quoFinal  = qNeg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign remFinal  = rNeg ? -prod[PROD_W-1:WIDTH] : prod[PROD_W-1:WIDTH];
`endif

    // Next-state and datapath step.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        prodNext    = prod;
        operandNext = operand;
        negProdNext = negProd;
        hiNext      = hiReg;
        loNext      = loReg;
        busyNext    = busyReg;
        doneNext    = 1'b0;
        mulSum      = '0;
`ifdef HILO_DIV_EN
        isDivNext   = isDiv;
        qNegNext    = qNeg;
        rNegNext    = rNeg;
        divZeroNext = 1'b0;
        divShift    = '0;
        divDiff     = '0;
`endif
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        OP_MTHI: hiNext = bus.OpA;
                        OP_MTLO: loNext = bus.OpA;
                        OP_MULT, OP_MULTU: begin
                            prodNext    = {{WIDTH{1'b0}}, absB};
                            operandNext = absA;
                            negProdNext = isSigned & (signA ^ signB);
                            counterNext = CNT_W'(WIDTH - 1);
                            busyNext    = 1'b1;
                            stateNext   = MUL;
`ifdef HILO_DIV_EN
                            isDivNext   = 1'b0;
`endif
                        end
`ifdef HILO_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            if (bus.OpB == '0) begin
                                doneNext    = 1'b1;
                                divZeroNext = 1'b1;
                            end else begin
                                prodNext    = {{WIDTH{1'b0}}, absA};
                                operandNext = absB;
                                qNegNext    = isSigned & (signA ^ signB);
                                rNegNext    = isSigned & signA;
                                isDivNext   = 1'b1;
                                counterNext = CNT_W'(WIDTH - 1);
                                busyNext    = 1'b1;
                                stateNext   = DIV;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL: begin
                // Add multiplicand into the upper half on a set LSB, then shift right.
                mulSum   = {1'b0, prod[PROD_W-1:WIDTH]} + (prod[0] ? {1'b0, operand} : '0);
                prodNext = {mulSum, prod[WIDTH-1:1]};
                if (counter == '0) stateNext = SIGN;
                else counterNext = counter - CNT_W'(1);
            end
`ifdef HILO_DIV_EN
            DIV: begin
                // Remainder in the upper half, dividend/quotient shifting through the lower half.
                divShift = {prod[PROD_W-1:WIDTH], prod[WIDTH-1]};
                if (divShift >= {1'b0, operand}) begin
                    divDiff  = divShift[WIDTH-1:0] - operand;
                    prodNext = {divDiff, prod[WIDTH-2:0], 1'b1};
                end else begin
                    prodNext = {divShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
                end
                if (counter == '0) stateNext = SIGN;
                else counterNext = counter - CNT_W'(1);
            end
`endif
            SIGN: begin
`ifdef HILO_DIV_EN
                if (isDiv) begin
                    hiNext = remFinal;
                    loNext = quoFinal;
                end else begin
                    hiNext = prodFinal[PROD_W-1:WIDTH];
                    loNext = prodFinal[WIDTH-1:0];
                end
`else
                hiNext = prodFinal[PROD_W-1:WIDTH];
                loNext = prodFinal[WIDTH-1:0];
`endif
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            counter    <= '0;
            prod       <= '0;
            operand    <= '0;
            negProd    <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
`ifdef HILO_DIV_EN
            isDiv      <= 1'b0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            divZeroReg <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            counter    <= counterNext;
            prod       <= prodNext;
            operand    <= operandNext;
            negProd    <= negProdNext;
            hiReg      <= hiNext;
            loReg      <= loNext;
            busyReg    <= busyNext;
            doneReg    <= doneNext;
`ifdef HILO_DIV_EN
            isDiv      <= isDivNext;
            qNeg       <= qNegNext;
            rNeg       <= rNegNext;
            divZeroReg <= divZeroNext;
`endif
        end
    end

    assign bus.Stall = busyReg & (bus.Start | bus.HiLoRead);
    assign bus.Busy  = busyReg;
    assign bus.Done  = doneReg;
    assign bus.HI    = hiReg;
    assign bus.LO    = loReg;
`ifdef HILO_DIV_EN
    assign bus.DivZero = divZeroReg;
`else
    assign bus.DivZero = 1'b0;
`endif
endmodule

// File: tb/tb_hilo_sequencer.sv
// Randomized self-checking bench for hilo_sequencer against an arithmetic HI/LO model.
module tb_hilo_sequencer;
    localparam int unsigned W = 32;
`ifdef HILO_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    hilo_sequencer_if #(.WIDTH(W)) bus();
    hilo_sequencer #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int checks = 0;
    int fails  = 0;
    logic [W-1:0] refHi = '0;
    logic [W-1:0] refLo = '0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 0 ignored, 1 immediate move, 2 iterative, 3 divide by zero
    function automatic int opKind(input logic [2:0] op, input logic [W-1:0] b);
        case (op)
            3'd0, 3'd1: return 2;
            3'd2, 3'd3: return !DivEn ? 0 : ((b == '0) ? 3 : 2);
            3'd4, 3'd5: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [2*W-1:0] opResult(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [W-1:0] hi,
                                                input logic [W-1:0] lo);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0:    return 64'(sa * sb);
            3'd1:    return 64'(ua * ub);
            3'd2:    return {W'(sa % sb), W'(sa / sb)};
            3'd3:    return {W'(ua % ub), W'(ua / ub)};
            3'd4:    return {a, lo};
            3'd5:    return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int kind, n, corrupt;
        logic [2*W-1:0] res;
        kind = opKind(op, b);
        res  = (kind == 1 || kind == 2) ? opResult(op, a, b, refHi, refLo) : {refHi, refLo};
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b;
        #1;
        checkEq($sformatf("stallIdle op%0d", op), 64'(bus.Stall), 64'(0));
        @(negedge Clk);
        bus.Start = 1'b0;
        checkEq($sformatf("doneStart op%0d", op), 64'(bus.Done), 64'(kind == 3));
        checkEq($sformatf("divZeroStart op%0d", op), 64'(bus.DivZero), 64'(kind == 3));
        checkEq($sformatf("busyStart op%0d", op), 64'(bus.Busy), 64'(kind == 2));
        if (kind == 2) begin
            n = 0;
            corrupt = 0;
            while (!bus.Done && n < 60) begin
                if (n == 5) begin
                    bus.HiLoRead = 1'b1;
                    #1;
                    checkEq($sformatf("stallRead op%0d", op), 64'(bus.Stall), 64'(1));
                    bus.HiLoRead = 1'b0;
                end
                if ({bus.HI, bus.LO} !== {refHi, refLo}) corrupt++;
                @(negedge Clk);
                n++;
            end
            checkEq($sformatf("latency op%0d", op), 64'(n), 64'(W + 1));
            checkEq($sformatf("holdPartial op%0d", op), 64'(corrupt), 64'(0));
            checkEq($sformatf("busyDone op%0d", op), 64'(bus.Busy), 64'(0));
            checkEq($sformatf("divZeroDone op%0d", op), 64'(bus.DivZero), 64'(0));
        end
        refHi = res[2*W-1:W];
        refLo = res[W-1:0];
        checkEq($sformatf("hi op%0d a=%0h b=%0h", op, a, b), 64'(bus.HI), 64'(refHi));
        checkEq($sformatf("lo op%0d a=%0h b=%0h", op, a, b), 64'(bus.LO), 64'(refLo));
        @(negedge Clk);
        checkEq($sformatf("donePulse op%0d", op), 64'(bus.Done), 64'(0));
        checkEq($sformatf("divZeroPulse op%0d", op), 64'(bus.DivZero), 64'(0));
    endtask

    // MULTU in flight: HiLoRead and a queued MTLO both stall; the MTLO lands in the Done cycle.
    task automatic stallScenario();
        int n, badStall;
        logic [W-1:0] mtloVal;
        mtloVal = $urandom;
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 3'd1; bus.OpA = 32'hFFFF_FFFF; bus.OpB = 32'd2;
        @(negedge Clk);
        bus.Start = 1'b0;
        n = 0;
        while (n < 10) begin
            if (n == 5) begin
                bus.HiLoRead = 1'b1;
                #1;
                checkEq("stallHiLoRead", 64'(bus.Stall), 64'(1));
                bus.HiLoRead = 1'b0;
            end
            @(negedge Clk);
            n++;
        end
        bus.Start = 1'b1; bus.Op = 3'd5; bus.OpA = mtloVal; bus.OpB = '0;
        #1;
        checkEq("stallStart", 64'(bus.Stall), 64'(1));
        badStall = 0;
        while (!bus.Done && n < 60) begin
            if (bus.Stall !== 1'b1) badStall++;
            @(negedge Clk);
            n++;
        end
        checkEq("stallHeld", 64'(badStall), 64'(0));
        checkEq("stallLatency", 64'(n), 64'(W + 1));
        checkEq("stallDoneCycle", 64'(bus.Stall), 64'(0));
        checkEq("multuHi", 64'(bus.HI), 64'(1));
        checkEq("multuLo", 64'(bus.LO), 64'(32'hFFFF_FFFE));
        @(negedge Clk);
        bus.Start = 1'b0;
        checkEq("mtloAfterDoneLo", 64'(bus.LO), 64'(mtloVal));
        checkEq("mtloAfterDoneHi", 64'(bus.HI), 64'(1));
        checkEq("mtloNoDone", 64'(bus.Done), 64'(0));
        refHi = 32'd1;
        refLo = mtloVal;
    endtask

    // Reset in the middle of an iterative operation.
    task automatic resetScenario();
        int doneSeen;
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = DivEn ? 3'd2 : 3'd0; bus.OpA = 32'd1000; bus.OpB = 32'd3;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (11) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        checkEq("midResetHi", 64'(bus.HI), 64'(0));
        checkEq("midResetLo", 64'(bus.LO), 64'(0));
        checkEq("midResetBusy", 64'(bus.Busy), 64'(0));
        refHi = '0;
        refLo = '0;
        doneSeen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Done) doneSeen++;
        end
        checkEq("midResetNoDone", 64'(doneSeen), 64'(0));
        runOp(3'd0, 32'd6, 32'd7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        bus.Start = 1'b0; bus.Op = '0; bus.OpA = '0; bus.OpB = '0; bus.HiLoRead = 1'b0;
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        checkEq("rstHi", 64'(bus.HI), 64'(0));
        checkEq("rstLo", 64'(bus.LO), 64'(0));
        checkEq("rstBusy", 64'(bus.Busy), 64'(0));
        checkEq("rstDone", 64'(bus.Done), 64'(0));
        checkEq("rstDivZero", 64'(bus.DivZero), 64'(0));
        Reset = 1'b1;

        runOp(3'd0, 32'hFFFF_FFFD, 32'd7);
        runOp(3'd3, 32'd100, 32'd7);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2);
        runOp(3'd4, 32'h0000_1234, 32'd0);
        runOp(3'd2, 32'd5, 32'd0);
        runOp(3'd0, 32'h8000_0000, 32'h8000_0000);
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(3'd2, 32'd10, 32'd3);
        runOp(3'd6, 32'hDEAD_BEEF, 32'd1);
        runOp(3'd7, 32'hCAFE_F00D, 32'd2);
        stallScenario();
        resetScenario();

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = W'($urandom);
            endcase
            runOp(op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
